// File: rtl/r16_stage_ctrl.sv
// rtl/r16_stage_ctrl.sv - radix-16 stage/group sequencing controller for a pipelined butterfly
//
// Purpose: accepts one 16-lane beat per cycle from upstream memory, walks group
// indices 0..N_GROUPS-1 for each of N_STAGES stages, tracks each issued beat
// through a PIPE_LAT-deep (valid, group) shift register, and signals stage and
// transform completion when the last result of a stage leaves the pipeline.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   one-cycle transform request (honoured only in IDLE)
//   in_valid / in_ready     upstream beat handshake
//   bf_en                   beat issued to the delay line and butterfly
//   grp_idx, stage_idx      group / stage of the issued beat
//   out_valid, out_grp_idx  butterfly result present, with its group index
//   stage_done, done        completion pulses
//   busy                    controller not in IDLE

module r16_stage_ctrl #(
    parameter int N_GROUPS = 4096,
    parameter int N_STAGES = 4,
    parameter int PIPE_LAT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bf_en,
    output logic [15:0] grp_idx,
    output logic [2:0]  stage_idx,
    output logic        out_valid,
    output logic [15:0] out_grp_idx,
    output logic        stage_done,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        FINISH = 2'd3
    } state_t;

    // Terminal-count compares keep the counters at fixed width; 65536 groups
    // ends at 16'hFFFF without ever relying on overflow.
    localparam logic [15:0] LAST_GRP = 16'(N_GROUPS - 1);
    localparam logic [2:0]  LAST_STG = 3'(N_STAGES - 1);

    state_t      state_q, state_d;
    logic [15:0] grp_q, grp_d;
    logic [2:0]  stg_q, stg_d;
    logic        pv_q [PIPE_LAT];
    logic        pv_d [PIPE_LAT];
    logic [15:0] pg_q [PIPE_LAT];
    logic [15:0] pg_d [PIPE_LAT];
    logic        stage_done_q, stage_done_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        last_arrive;
    logic        active;

    assign in_ready    = (state_q == RUN);
    assign bf_en       = in_valid & in_ready;
    assign grp_idx     = grp_q;
    assign stage_idx   = stg_q;
    assign out_valid   = pv_q[PIPE_LAT-1];
    assign out_grp_idx = pg_q[PIPE_LAT-1];
    assign stage_done  = stage_done_q;
    assign done        = done_q;
    assign busy        = busy_q;

    always_comb begin
        pv_d[0] = bf_en;
        pg_d[0] = grp_q;
        for (int i = 1; i < PIPE_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pg_d[i] = pg_q[i-1];
        end

        // The last token of the stage reaches the output register next cycle.
        // Looking one cycle ahead lets stage_done/done be registered yet line
        // up exactly with out_valid of that token. Stages never overlap, so
        // the only token carrying LAST_GRP is the current stage's final beat.
        active      = (state_q == RUN) || (state_q == DRAIN);
        last_arrive = active && pv_d[PIPE_LAT-1] && (pg_d[PIPE_LAT-1] == LAST_GRP);

        state_d = state_q;
        grp_d   = grp_q;
        stg_d   = stg_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    grp_d   = 16'd0;
                    stg_d   = 3'd0;
                end
            end
            RUN: begin
                if (bf_en) begin
                    if (grp_q == LAST_GRP) begin
                        state_d = DRAIN;
                    end else begin
                        grp_d = grp_q + 16'd1;
                    end
                end
            end
            DRAIN: begin
                // Only a non-final stage can get here with stage_done high;
                // the final one has already been diverted to FINISH.
                if (stage_done_q) begin
                    state_d = RUN;
                    grp_d   = 16'd0;
                    stg_d   = stg_q + 3'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Final stage: FINISH is entered so that it coincides with the last
        // result and its stage_done, giving done in that same cycle.
        if (last_arrive && (stg_q == LAST_STG)) begin
            state_d = FINISH;
        end

        stage_done_d = last_arrive;
        done_d       = last_arrive && (stg_q == LAST_STG);
        busy_d       = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grp_q        <= 16'd0;
            stg_q        <= 3'd0;
            stage_done_q <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pv_q[i] <= 1'b0;
                pg_q[i] <= 16'd0;
            end
        end else begin
            state_q      <= state_d;
            grp_q        <= grp_d;
            stg_q        <= stg_d;
            stage_done_q <= stage_done_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            for (int i = 0; i < PIPE_LAT; i++) begin
                pv_q[i] <= pv_d[i];
                pg_q[i] <= pg_d[i];
            end
        end
    end

endmodule

// File: tb/tb_r16_stage_ctrl.sv
// tb/tb_r16_stage_ctrl.sv - self-checking bench for r16_stage_ctrl
module tb_r16_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, in_valid;
    logic        in_ready, bf_en, out_valid, stage_done, done, busy;
    logic [15:0] grp_idx, out_grp_idx;
    logic [2:0]  stage_idx;

    logic        rst_b, start_b, iv_b;
    logic        rdy_b, bf_b, ov_b, sd_b, dn_b, busy_b;
    logic [15:0] grp_b, og_b;
    logic [2:0]  stg_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit big_done = 1'b0;

    r16_stage_ctrl #(.N_GROUPS(4), .N_STAGES(2), .PIPE_LAT(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .bf_en(bf_en), .grp_idx(grp_idx), .stage_idx(stage_idx),
        .out_valid(out_valid), .out_grp_idx(out_grp_idx), .stage_done(stage_done),
        .done(done), .busy(busy)
    );

    r16_stage_ctrl #(.N_GROUPS(65536), .N_STAGES(1), .PIPE_LAT(3)) u_big (
        .clk(clk), .rst_n(rst_b), .start(start_b), .in_valid(iv_b),
        .in_ready(rdy_b), .bf_en(bf_b), .grp_idx(grp_b), .stage_idx(stg_b),
        .out_valid(ov_b), .out_grp_idx(og_b), .stage_done(sd_b),
        .done(dn_b), .busy(busy_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic start;
        logic iv;
        logic rdy;
        logic bf;
        int   grp;
        int   stg;
        logic ov;
        int   og;
        logic sd;
        logic dn;
        logic busy;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic s, input logic iv, input logic rdy, input logic bf,
                                input int grp, input int stg, input logic ov, input int og,
                                input logic sd, input logic dn, input logic bz);
        vec_t v;
        v.start = s; v.iv = iv; v.rdy = rdy; v.bf = bf; v.grp = grp; v.stg = stg;
        v.ov = ov; v.og = og; v.sd = sd; v.dn = dn; v.busy = bz;
        return v;
    endfunction

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Applies the 16-cycle nominal transform; extra_starts adds ignored
    // start pulses in cycles 3 (RUN) and 14 (coincident with done).
    task automatic run_table(input string tag, input bit extra_starts);
        for (int c = 0; c < 16; c++) begin
            @(posedge clk);
            #1;
            start    = tbl[c].start | (extra_starts && (c == 3 || c == 14));
            in_valid = tbl[c].iv;
            #3;
            check($sformatf("%s c%0d in_ready", tag, c), 32'(in_ready), 32'(tbl[c].rdy));
            check($sformatf("%s c%0d bf_en", tag, c), 32'(bf_en), 32'(tbl[c].bf));
            check($sformatf("%s c%0d grp_idx", tag, c), 32'(grp_idx), tbl[c].grp);
            check($sformatf("%s c%0d stage_idx", tag, c), 32'(stage_idx), tbl[c].stg);
            check($sformatf("%s c%0d out_valid", tag, c), 32'(out_valid), 32'(tbl[c].ov));
            check($sformatf("%s c%0d out_grp_idx", tag, c), 32'(out_grp_idx), tbl[c].og);
            check($sformatf("%s c%0d stage_done", tag, c), 32'(stage_done), 32'(tbl[c].sd));
            check($sformatf("%s c%0d done", tag, c), 32'(done), 32'(tbl[c].dn));
            check($sformatf("%s c%0d busy", tag, c), 32'(busy), 32'(tbl[c].busy));
        end
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        //            start iv rdy bf grp stg ov og sd dn busy
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        tbl[2]  = mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1);
        tbl[3]  = mk(0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1);
        tbl[4]  = mk(0, 1, 1, 1, 3, 0, 1, 0, 0, 0, 1);
        tbl[5]  = mk(0, 1, 0, 0, 3, 0, 1, 1, 0, 0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 3, 0, 1, 2, 0, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 3, 0, 1, 3, 1, 0, 1);
        tbl[8]  = mk(0, 1, 1, 1, 0, 1, 0, 3, 0, 0, 1);
        tbl[9]  = mk(0, 1, 1, 1, 1, 1, 0, 3, 0, 0, 1);
        tbl[10] = mk(0, 1, 1, 1, 2, 1, 0, 3, 0, 0, 1);
        tbl[11] = mk(0, 1, 1, 1, 3, 1, 1, 0, 0, 0, 1);
        tbl[12] = mk(0, 1, 0, 0, 3, 1, 1, 1, 0, 0, 1);
        tbl[13] = mk(0, 1, 0, 0, 3, 1, 1, 2, 0, 0, 1);
        tbl[14] = mk(0, 1, 0, 0, 3, 1, 1, 3, 1, 1, 1);
        tbl[15] = mk(0, 1, 0, 0, 3, 1, 0, 3, 0, 0, 0);

        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #4;
        check("reset in_ready", 32'(in_ready), 0);
        check("reset bf_en", 32'(bf_en), 0);
        check("reset busy", 32'(busy), 0);
        check("reset grp_idx", 32'(grp_idx), 0);
        check("reset stage_idx", 32'(stage_idx), 0);
        check("reset out_valid", 32'(out_valid), 0);
        #1 rst_n = 1'b1; in_valid = 1'b0;

        // Nominal transform.
        run_table("nominal", 1'b0);

        // Extra start pulses in RUN and coincident with done are ignored.
        do_reset();
        run_table("restart", 1'b1);

        // Stall of 5 cycles after the second beat of stage 0.
        do_reset();
        begin
            int n_bf = 0;
            int done_cyc = -1;
            int sd_cnt = 0;
            int sd_first = -1;
            for (int c = 0; c < 24; c++) begin
                @(posedge clk);
                #1;
                start    = (c == 0);
                in_valid = !(c >= 3 && c <= 7);
                #3;
                if (bf_en) n_bf++;
                if (c >= 3 && c <= 7)
                    check($sformatf("stall c%0d grp_idx hold", c), 32'(grp_idx), 2);
                if (stage_done) begin
                    sd_cnt++;
                    if (sd_first < 0) sd_first = c;
                end
                if (done) done_cyc = c;
                if (c == 20) check("stall busy after done", 32'(busy), 0);
            end
            #1 start = 1'b0;
            check("stall bf_en count", 32'(n_bf), 8);
            check("stall first stage_done cycle", 32'(sd_first), 12);
            check("stall stage_done count", 32'(sd_cnt), 2);
            check("stall done cycle", 32'(done_cyc), 19);
        end

        // Asynchronous reset during DRAIN of stage 0.
        do_reset();
        begin
            int spurious = 0;
            for (int c = 0; c < 5; c++) begin
                @(posedge clk);
                #1;
                start = (c == 0); in_valid = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            #1 rst_n = 1'b0;
            #1;
            check("midrst in_ready", 32'(in_ready), 0);
            check("midrst bf_en", 32'(bf_en), 0);
            check("midrst grp_idx", 32'(grp_idx), 0);
            check("midrst stage_idx", 32'(stage_idx), 0);
            check("midrst out_valid", 32'(out_valid), 0);
            check("midrst out_grp_idx", 32'(out_grp_idx), 0);
            check("midrst stage_done", 32'(stage_done), 0);
            check("midrst done", 32'(done), 0);
            check("midrst busy", 32'(busy), 0);
            for (int c = 0; c < 6; c++) begin
                @(posedge clk);
                #1 if (c == 2) rst_n = 1'b1;
                #3 if (stage_done || done || busy) spurious++;
            end
            check("midrst no stage_done/done/busy", 32'(spurious), 0);
        end
        run_table("after_rst", 1'b0);

        wait (big_done);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // 65536-group single-stage transform runs alongside the directed tests.
    initial begin
        int exp_grp = 0;
        int order_err = 0;
        int n_ov = 0;
        int n_sd = 0;
        int max_grp = 0;
        int done_cyc = -1;
        logic done_ok = 1'b0;
        logic [15:0] grp_at_done = 16'd0;
        rst_b = 1'b0; start_b = 1'b0; iv_b = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        for (int c = 0; c < 70000 && done_cyc < 0; c++) begin
            @(posedge clk);
            #1 start_b = (c == 0);
            #3;
            if (bf_b) begin
                if (int'(grp_b) != exp_grp) order_err++;
                exp_grp++;
            end
            if (int'(grp_b) > max_grp) max_grp = int'(grp_b);
            if (ov_b) n_ov++;
            if (sd_b) n_sd++;
            if (dn_b) begin
                done_cyc    = c;
                done_ok     = sd_b && ov_b && (og_b == 16'hFFFF);
                grp_at_done = grp_b;
            end
        end
        check("big done reached at cycle", 32'(done_cyc), 65539);
        check("big group order errors", 32'(order_err), 0);
        check("big bf_en count", 32'(exp_grp), 65536);
        check("big max grp_idx", 32'(max_grp), 65535);
        check("big grp_idx at done (no wrap)", 32'(grp_at_done), 65535);
        check("big out_valid count", 32'(n_ov), 65536);
        check("big stage_done count", 32'(n_sd), 1);
        check("big done with stage_done and out_grp 65535", 32'(done_ok), 1);
        big_done = 1'b1;
    end

endmodule
